// File: rtl/wdt_pkg.sv
// wdt_pkg: shared types and constants for the watchdog bite controller.
//   wdt_bite_state_t : FSM state encoding (DISARMED=0, ARMED=1, WARN=2, BITE=3)
//   WDT_KEY1/WDT_KEY2: default two-key service sequence
//   WDT_STATE_W      : width of the exported state field
//   wdt_sat_inc8     : saturating 8-bit increment
package wdt_pkg;

  localparam int WDT_STATE_W = 2;

  localparam logic [7:0] WDT_KEY1 = 8'hA5;
  localparam logic [7:0] WDT_KEY2 = 8'h5A;

  typedef enum logic [WDT_STATE_W-1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    WARN     = 2'd2,
    BITE     = 2'd3
  } wdt_bite_state_t;

  function automatic logic [7:0] wdt_sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/wdt_bite_ctrl_if.sv
// wdt_bite_ctrl_if: control/status bundle of the watchdog bite controller.
//   en          : arm request (level)
//   wdt_tick    : one-cycle timeout pulse from the watchdog counter
//   kick_valid  : service write strobe
//   kick_key    : service write data
//   wdt_clr     : one-cycle clear pulse back to the watchdog counter
//   irq         : warning interrupt (level)
//   sys_rst_req : system reset request pulse
//   state       : current FSM state
//   timeout_cnt : saturating count of accepted timeouts
// Modports: master drives the requests (software/counter side),
//           slave is the controller itself.
interface wdt_bite_ctrl_if;
  import wdt_pkg::*;

  logic                   en;
  logic                   wdt_tick;
  logic                   kick_valid;
  logic [7:0]             kick_key;
  logic                   wdt_clr;
  logic                   irq;
  logic                   sys_rst_req;
  logic [WDT_STATE_W-1:0] state;
  logic [7:0]             timeout_cnt;

  modport master (
    output en, wdt_tick, kick_valid, kick_key,
    input  wdt_clr, irq, sys_rst_req, state, timeout_cnt
  );

  modport slave (
    input  en, wdt_tick, kick_valid, kick_key,
    output wdt_clr, irq, sys_rst_req, state, timeout_cnt
  );

endinterface

// File: rtl/wdt_rst_stretch.sv
// wdt_rst_stretch: loadable down-counter that stretches the bite into a
// fixed-width reset request.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load len and begin the pulse
//   len        : pulse length minus one
//   busy       : registered, high for len+1 cycles after start
//   done       : high during the last busy cycle
module wdt_rst_stretch #(
  parameter  int RST_CYCLES = 16,
  localparam int CW         = $clog2(RST_CYCLES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] len,
  output logic          busy,
  output logic          done
);

  logic [CW-1:0] cnt;

  // Counting down from len to zero keeps busy high for len+1 cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= len;
    end else if (busy) begin
      if (cnt == '0) begin
        busy <= 1'b0;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign done = busy && (cnt == '0);

endmodule

// File: rtl/wdt_bite_ctrl.sv
// wdt_bite_ctrl: two-stage watchdog response controller.
//   First unserviced timeout raises irq; a second timeout without a valid
//   KEY1/KEY2 service sequence asserts sys_rst_req for RST_CYCLES cycles.
//   A clear pulse is returned to the watchdog counter on arm, service and
//   bite exit.
// Parameters: RST_CYCLES (>=1), KEY1, KEY2.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : wdt_bite_ctrl_if.slave (en, wdt_tick, kick_valid, kick_key in;
//           wdt_clr, irq, sys_rst_req, state, timeout_cnt out)
// Build option: WDT_BITE_LOCK_EN -- when defined, en is ignored once the
//   watchdog has been armed, until the next rst_n.
module wdt_bite_ctrl
  import wdt_pkg::*;
#(
  parameter int         RST_CYCLES = 16,
  parameter logic [7:0] KEY1       = WDT_KEY1,
  parameter logic [7:0] KEY2       = WDT_KEY2
) (
  input logic           clk,
  input logic           rst_n,
  wdt_bite_ctrl_if.slave bus
);

  localparam int            CW       = $clog2(RST_CYCLES + 1);
  localparam logic [CW-1:0] BITE_LEN = CW'(RST_CYCLES - 1);

  wdt_bite_state_t state_q, state_d;
  logic            irq_q, irq_d;
  logic            clr_q, clr_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            k1_q, k1_d;
  logic            en_eff;
  logic            armed_like;
  logic            kick_hit;
  logic            kick_done;
  logic            tick_ok;
  logic            bite_start;
  logic            bite_busy;
  logic            bite_done;

`ifdef WDT_BITE_LOCK_EN
  // Leaving DISARMED is only possible through ARMED, so any other state
  // means the lock has engaged; only rst_n returns to DISARMED.
  assign en_eff = bus.en || (state_q != DISARMED);
`else
  assign en_eff = bus.en;
`endif

  assign armed_like = (state_q == ARMED) || (state_q == WARN);
  assign kick_hit   = bus.kick_valid && (bus.kick_key == KEY2) && k1_q;
  assign kick_done  = armed_like && kick_hit;

  wdt_rst_stretch #(
    .RST_CYCLES(RST_CYCLES)
  ) u_stretch (
    .clk  (clk),
    .rst_n(rst_n),
    .start(bite_start),
    .len  (BITE_LEN),
    .busy (bite_busy),
    .done (bite_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DISARMED;
      irq_q   <= 1'b0;
      clr_q   <= 1'b0;
      cnt_q   <= 8'd0;
      k1_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_d;
      clr_q   <= clr_d;
      cnt_q   <= cnt_d;
      k1_q    <= k1_d;
    end
  end

  // Priority inside ARMED/WARN: disarm, then kick completion, then tick.
  // A tick that loses to a kick or a disarm is not counted.
  always_comb begin
    state_d    = state_q;
    clr_d      = 1'b0;
    k1_d       = k1_q;
    tick_ok    = 1'b0;
    bite_start = 1'b0;

    if (!armed_like) begin
      k1_d = 1'b0;
    end else if (bus.kick_valid) begin
      k1_d = (bus.kick_key == KEY1) && !kick_hit;
    end

    unique case (state_q)
      DISARMED: begin
        if (bus.en) begin
          state_d = ARMED;
          clr_d   = 1'b1;
        end
      end
      ARMED, WARN: begin
        if (!en_eff) begin
          state_d = DISARMED;
        end else if (kick_done) begin
          state_d = ARMED;
          clr_d   = 1'b1;
        end else if (bus.wdt_tick) begin
          tick_ok = 1'b1;
          if (state_q == ARMED) begin
            state_d = WARN;
          end else begin
            state_d    = BITE;
            bite_start = 1'b1;
          end
        end
      end
      BITE: begin
        if (bite_done) begin
          state_d = ARMED;
          clr_d   = 1'b1;
        end
      end
      default: state_d = DISARMED;
    endcase

    cnt_d = tick_ok ? wdt_sat_inc8(cnt_q) : cnt_q;
    irq_d = (state_d == WARN);
  end

  assign bus.state       = state_q;
  assign bus.irq         = irq_q;
  assign bus.wdt_clr     = clr_q;
  assign bus.timeout_cnt = cnt_q;
  assign bus.sys_rst_req = bite_busy;

endmodule
